rb2_frame_tx: RTL and testbench

RB2_FRAME_TX -- requirements
Module: rb2_frame_tx

---
 rtl/rb2_frame_pkg.sv | 24 ++
 rtl/frame_piso.sv | 44 ++++
 rtl/rb2_frame_tx.sv | 115 +++++++++++
 tb/tb_rb2_frame_tx.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rb2_frame_pkg.sv
// ============================================================================
// rb2_frame_pkg : shared types and constants for the RB2 frame transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

package rb2_frame_pkg;

    localparam int ADDR_W         = 3;
    localparam int DATA_W         = 18;
    localparam int FRAME_BITS     = ADDR_W + DATA_W;
    localparam int FRAME_BITS_PAR = FRAME_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/frame_piso.sv
// ============================================================================
// frame_piso : parallel-load, MSB-first shift register with bit counter
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_piso #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] word,
    output logic             sd,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;

    // The shift after the last bit fills the register with zeros, so sd idles low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_sr  <= word;
            r_cnt <= CNT_W'(WIDTH - 1);
        end else if (shift) begin
            r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
            if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign sd   = r_sr[WIDTH-1];
    assign last = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/rb2_frame_tx.sv
// ============================================================================
// rb2_frame_tx : reads RB2 words 0..FRAME_CNT-1 and serialises {addr,data}
// Optional macro FRAME_PARITY_EN appends an even-parity bit to each frame.
// Rev 1.0
// ============================================================================
`default_nettype none

module rb2_frame_tx
    import rb2_frame_pkg::*;
#(
    parameter int FRAME_CNT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              RB2_RW,
    output logic [ADDR_W-1:0] RB2_A,
    output logic [DATA_W-1:0] RB2_D,
    input  logic [DATA_W-1:0] RB2_Q,
    output logic              sen,
    output logic              sd,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_N = ADDR_W'(FRAME_CNT - 1);

`ifdef FRAME_PARITY_EN
    localparam int FW = FRAME_BITS_PAR;
`else
    localparam int FW = FRAME_BITS;
`endif

    state_t              r_state;
    logic [ADDR_W-1:0]   r_n;
    logic [FRAME_BITS-1:0] w_frame;
    logic [FW-1:0]       w_word;
    logic                w_load;
    logic                w_shift;
    logic                w_last;

    assign w_frame = {r_n, RB2_Q};

`ifdef FRAME_PARITY_EN
    assign w_word = {w_frame, ^w_frame};
`else
    assign w_word = w_frame;
`endif

    assign w_load  = (r_state == S_WAIT);
    assign w_shift = (r_state == S_SHIFT);

    assign RB2_RW = 1'b1;
    assign RB2_D  = '0;
    assign RB2_A  = r_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            sen     <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n     <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                end
                // RB2_Q is valid here; the shifter loads on this closing edge.
                S_WAIT: begin
                    sen     <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_last) begin
                        sen <= 1'b1;
                        if (r_n < LAST_N) begin
                            r_n     <= r_n + 1'b1;
                            r_state <= S_READ;
                        end else begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    frame_piso #(
        .WIDTH (FW)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .word  (w_word),
        .sd    (sd),
        .last  (w_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_rb2_frame_tx.sv
// ============================================================================
// tb_rb2_frame_tx : randomized self-checking bench for rb2_frame_tx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rb2_frame_tx;

`ifdef FRAME_PARITY_EN
    localparam int FL  = 22;
    localparam int PAR = 1;
`else
    localparam int FL  = 21;
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start8 = 1'b0;
    logic start1 = 1'b0;
    always #5 clk = ~clk;

    logic        rw8, rw1, sen8, sen1, sd8, sd1, done8, done1;
    logic [2:0]  a8, a1;
    logic [17:0] d8, d1, q8, q1;
    logic [17:0] mem8 [8];
    logic [17:0] mem1 [8];

    always @(posedge clk) begin
        q8 <= mem8[a8];
        q1 <= mem1[a1];
    end

    rb2_frame_tx #(.FRAME_CNT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .RB2_RW(rw8), .RB2_A(a8),
        .RB2_D(d8), .RB2_Q(q8), .sen(sen8), .sd(sd8), .done(done8)
    );

    rb2_frame_tx #(.FRAME_CNT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .RB2_RW(rw1), .RB2_A(a1),
        .RB2_D(d1), .RB2_Q(q1), .sen(sen1), .sd(sd1), .done(done1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Frame observer: reconstructs frames from the serial pins.
    bit              in8 = 0, have8 = 0, in1 = 0;
    longint unsigned cur8, cur1;
    int              len8, len1, last_bit8;
    longint unsigned word_q8[$], word_q1[$];
    int              len_q8[$], fall_q8[$], gap_q8[$], done_q8[$];
    int              len_q1[$], fall_q1[$], done_q1[$];
    int              sd_viol = 0, rw_viol = 0;

    always @(negedge clk) begin
        if (sen8 === 1'b0) begin
            if (!in8) begin
                in8 = 1; cur8 = 0; len8 = 0;
                fall_q8.push_back(cyc);
                if (have8) gap_q8.push_back(cyc - last_bit8 - 1);
            end
            cur8 = {cur8[62:0], sd8};
            len8++;
        end else if (in8) begin
            in8 = 0;
            word_q8.push_back(cur8); len_q8.push_back(len8);
            last_bit8 = cyc - 1; have8 = 1;
        end
        if (sen1 === 1'b0) begin
            if (!in1) begin
                in1 = 1; cur1 = 0; len1 = 0;
                fall_q1.push_back(cyc);
            end
            cur1 = {cur1[62:0], sd1};
            len1++;
        end else if (in1) begin
            in1 = 0;
            word_q1.push_back(cur1); len_q1.push_back(len1);
        end
        if ((sen8 === 1'b1 && sd8 !== 1'b0) || (sen1 === 1'b1 && sd1 !== 1'b0)) sd_viol++;
        if (rw8 !== 1'b1 || rw1 !== 1'b1) rw_viol++;
        if (done8 === 1'b1) done_q8.push_back(cyc);
        if (done1 === 1'b1) done_q1.push_back(cyc);
    end

    // Reference: frame = {address, cell}, optionally followed by even parity.
    function automatic longint unsigned exp_word(input int a, input logic [17:0] d);
        longint unsigned w;
        w = (longint'(a) << 18) | longint'(d);
        if (PAR != 0) w = (w << 1) | longint'($countones(w) & 1);
        return w;
    endfunction

    task automatic clear8();
        in8 = 0; have8 = 0;
        word_q8.delete(); len_q8.delete(); fall_q8.delete();
        gap_q8.delete(); done_q8.delete();
    endtask

    task automatic fill8();
        for (int i = 0; i < 8; i++) mem8[i] = 18'($urandom);
    endtask

    task automatic pulse8(output int k);
        @(negedge clk);
        start8 = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done8(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_q8.size() > 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 6;
        if (sen8 !== 1'b1)  begin n_bad++; $display("FAIL reset_sen got=%b want=1", sen8); end
        if (sd8 !== 1'b0)   begin n_bad++; $display("FAIL reset_sd got=%b want=0", sd8); end
        if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done8); end
        if (a8 !== 3'd0)    begin n_bad++; $display("FAIL reset_addr got=%0d want=0", a8); end
        if (rw8 !== 1'b1)   begin n_bad++; $display("FAIL reset_rw got=%b want=1", rw8); end
        if (sen1 !== 1'b1)  begin n_bad++; $display("FAIL reset_sen1 got=%b want=1", sen1); end
        rst = 1'b0;
        clear8();
        repeat (6) @(negedge clk);
        #1;
        n_cmp += 2;
        if (fall_q8.size() != 0) begin n_bad++; $display("FAIL idle_after_reset frames=%0d want=0", fall_q8.size()); end
        if (sen8 !== 1'b1) begin n_bad++; $display("FAIL idle_sen got=%b want=1", sen8); end
    endtask

    task automatic test_frame_cell3();
        int k; bit ok;
        logic [20:0] lit;
        lit = 21'b011_10_1010_0101_1100_0011;
        fill8();
        mem8[3] = 18'h2A5C3;
        clear8();
        pulse8(k);
        wait_done8(400, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL cell3_timeout got=no_done want=done"); end
        n_cmp++;
        if (word_q8.size() != 8) begin
            n_bad++; $display("FAIL cell3_count got=%0d want=8", word_q8.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp += 2;
                if (word_q8[i] != exp_word(i, mem8[i]))
                    begin n_bad++; $display("FAIL cell3_word%0d got=%h want=%h", i, word_q8[i], exp_word(i, mem8[i])); end
                if (len_q8[i] != FL)
                    begin n_bad++; $display("FAIL cell3_len%0d got=%0d want=%0d", i, len_q8[i], FL); end
            end
            n_cmp++;
            if (21'(word_q8[3] >> PAR) !== lit)
                begin n_bad++; $display("FAIL cell3_literal got=%b want=%b", 21'(word_q8[3] >> PAR), lit); end
        end
    endtask

    task automatic test_latency_gaps();
        int k; bit ok;
        fill8();
        clear8();
        pulse8(k);
        wait_done8(400, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL lat_timeout got=no_done want=done"); end
        // Start during the DONE cycle must not launch a new run.
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n_cmp += 3;
        if (fall_q8.size() < 1 || fall_q8[0] != k + 2)
            begin n_bad++; $display("FAIL latency got=%0d want=%0d", fall_q8.size() ? fall_q8[0] : -1, k + 2); end
        if (gap_q8.size() != 7)
            begin n_bad++; $display("FAIL gap_count got=%0d want=7", gap_q8.size()); end
        if (done_q8.size() < 1 || done_q8[0] != k + 2 + 8 * FL + 7 * 2)
            begin n_bad++; $display("FAIL done_time got=%0d want=%0d", done_q8.size() ? done_q8[0] : -1, k + 2 + 8 * FL + 14); end
        foreach (gap_q8[i]) begin
            n_cmp++;
            if (gap_q8[i] != 2) begin n_bad++; $display("FAIL gap%0d got=%0d want=2", i, gap_q8[i]); end
        end
        repeat (20) @(negedge clk);
        #1;
        n_cmp += 4;
        if (done_q8.size() != 1) begin n_bad++; $display("FAIL done_pulses got=%0d want=1", done_q8.size()); end
        if (fall_q8.size() != 8) begin n_bad++; $display("FAIL done_start_ignored frames=%0d want=8", fall_q8.size()); end
        if (sen8 !== 1'b1) begin n_bad++; $display("FAIL sen_after_done got=%b want=1", sen8); end
        if (sd_viol != 0) begin n_bad++; $display("FAIL sd_idle_low got=%0d want=0", sd_viol); end
    endtask

    task automatic test_back_to_back_start();
        int k, k2; bit ok;
        fill8();
        clear8();
        pulse8(k);
        for (int i = 0; i < 300 && fall_q8.size() < 3; i++) begin @(negedge clk); #1; end
        repeat (5) @(negedge clk);
        pulse8(k2);
        wait_done8(400, ok);
        repeat (10) @(negedge clk);
        #1;
        n_cmp += 2;
        if (!ok) begin n_bad++; $display("FAIL b2b_timeout got=no_done want=done"); end
        if (word_q8.size() != 8) begin
            n_bad++; $display("FAIL b2b_count got=%0d want=8", word_q8.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp += 2;
                if (int'(word_q8[i] >> (18 + PAR)) != i)
                    begin n_bad++; $display("FAIL b2b_addr%0d got=%0d want=%0d", i, word_q8[i] >> (18 + PAR), i); end
                if (word_q8[i] != exp_word(i, mem8[i]))
                    begin n_bad++; $display("FAIL b2b_word%0d got=%h want=%h", i, word_q8[i], exp_word(i, mem8[i])); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int k; bit ok;
        fill8();
        clear8();
        pulse8(k);
        for (int i = 0; i < 400 && !(fall_q8.size() == 5 && in8 && len8 == 11); i++) begin
            @(negedge clk); #1;
        end
        n_cmp++;
        if (!(fall_q8.size() == 5 && in8 && len8 == 11))
            begin n_bad++; $display("FAIL rst_reach_bit10 frames=%0d len=%0d want=5/11", fall_q8.size(), len8); end
        rst = 1'b1;
        #1;
        n_cmp += 3;
        if (sen8 !== 1'b1)  begin n_bad++; $display("FAIL rst_async_sen got=%b want=1", sen8); end
        if (sd8 !== 1'b0)   begin n_bad++; $display("FAIL rst_async_sd got=%b want=0", sd8); end
        if (done8 !== 1'b0) begin n_bad++; $display("FAIL rst_async_done got=%b want=0", done8); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        clear8();
        repeat (8) @(negedge clk);
        #1;
        n_cmp++;
        if (fall_q8.size() != 0) begin n_bad++; $display("FAIL rst_no_resume frames=%0d want=0", fall_q8.size()); end
        pulse8(k);
        wait_done8(400, ok);
        n_cmp += 2;
        if (!ok) begin n_bad++; $display("FAIL rst_restart_timeout got=no_done want=done"); end
        if (word_q8.size() != 8 || word_q8[0] != exp_word(0, mem8[0]))
            begin n_bad++; $display("FAIL rst_restart_addr0 frames=%0d got=%h want=%h", word_q8.size(), word_q8.size() ? word_q8[0] : 0, exp_word(0, mem8[0])); end
    endtask

    task automatic test_cell0();
        int k; bit ok;
        longint unsigned want;
        fill8();
        mem8[0] = 18'h00001;
        want = (PAR != 0) ? 64'd3 : 64'd1;
        clear8();
        pulse8(k);
        wait_done8(400, ok);
        n_cmp += 3;
        if (!ok) begin n_bad++; $display("FAIL cell0_timeout got=no_done want=done"); end
        if (word_q8.size() < 1 || word_q8[0] != want)
            begin n_bad++; $display("FAIL cell0_word got=%h want=%h", word_q8.size() ? word_q8[0] : 0, want); end
        if (len_q8.size() < 1 || len_q8[0] != FL)
            begin n_bad++; $display("FAIL cell0_len got=%0d want=%0d", len_q8.size() ? len_q8[0] : -1, FL); end
    endtask

    task automatic test_single_frame();
        int k; bit ok;
        for (int i = 0; i < 8; i++) mem1[i] = 18'($urandom);
        word_q1.delete(); len_q1.delete(); fall_q1.delete(); done_q1.delete();
        @(negedge clk);
        start1 = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (done_q1.size() > 0) begin ok = 1; break; end
        end
        repeat (10) @(negedge clk);
        #1;
        n_cmp += 6;
        if (!ok) begin n_bad++; $display("FAIL single_timeout got=no_done want=done"); end
        if (word_q1.size() != 1) begin n_bad++; $display("FAIL single_count got=%0d want=1", word_q1.size()); end
        if (word_q1.size() > 0 && word_q1[0] != exp_word(0, mem1[0]))
            begin n_bad++; $display("FAIL single_word got=%h want=%h", word_q1[0], exp_word(0, mem1[0])); end
        if (len_q1.size() > 0 && len_q1[0] != FL)
            begin n_bad++; $display("FAIL single_len got=%0d want=%0d", len_q1[0], FL); end
        if (done_q1.size() != 1 || done_q1[0] != k + 2 + FL)
            begin n_bad++; $display("FAIL single_done n=%0d got=%0d want=%0d", done_q1.size(), done_q1.size() ? done_q1[0] : -1, k + 2 + FL); end
        if (rw_viol != 0) begin n_bad++; $display("FAIL rw_held got=%0d want=0", rw_viol); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin mem8[i] = '0; mem1[i] = '0; end
        test_reset();
        test_frame_cell3();
        test_latency_gaps();
        test_back_to_back_start();
        test_reset_mid_frame();
        test_cell0();
        test_single_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
